vga_timing_gen: RTL and testbench

- Upstream stage of the picture-display datapath: generates 640x480@60 VGA timing from a 25 MHz pixel clock.
- Drives the pixel address pair (h_addr, v_addr) to the display/ROM stage and takes back its 24-bit vga_data after a fixed read latency.
- Delays the sync and blank signals by that latency and registers everything at the output, so the pins carry RGB, sync and blank aligned to the same pixel.

---
 rtl/vga_timing_gen_pkg.sv | 36 +++
 rtl/vga_timing_gen_delay_line.sv | 35 +++
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 tb/tb_vga_timing_gen.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants and types for the 640x480@60 VGA timing generator.
//   - Horizontal/vertical visible, porch and sync widths plus line/frame totals.
//   - Sync polarity (both syncs active low).
//   - tim_t: the {vis, hs, vs} bundle carried down the alignment delay line.
package vga_timing_gen_pkg;

    localparam logic [9:0] H_VIS  = 10'd640;
    localparam logic [9:0] H_FP   = 10'd16;
    localparam logic [9:0] H_SYNC = 10'd96;
    localparam logic [9:0] H_BP   = 10'd48;
    localparam logic [9:0] V_VIS  = 10'd480;
    localparam logic [9:0] V_FP   = 10'd10;
    localparam logic [9:0] V_SYNC = 10'd2;
    localparam logic [9:0] V_BP   = 10'd33;

    localparam logic [9:0] H_TOT = H_VIS + H_FP + H_SYNC + H_BP;  // 800
    localparam logic [9:0] V_TOT = V_VIS + V_FP + V_SYNC + V_BP;  // 525

    localparam logic SYNC_ACT = 1'b0;

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
    } tim_t;

    // Idle bundle: blanked, both syncs inactive.
    localparam tim_t TIM_RST = '{vis: 1'b0, hs: ~SYNC_ACT, vs: ~SYNC_ACT};

    // True when lo <= x < lo + len.
    function automatic logic in_range(input logic [9:0] x, input logic [9:0] lo,
                                      input logic [9:0] len);
        return (x >= lo) && (x < lo + len);
    endfunction

endpackage

// File: rtl/vga_timing_gen_delay_line.sv
// vga_delay_line: N-stage, W-bit shift register with asynchronous active-low
// reset to a parameterised value. N must be at least 1.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset, loads RST_VAL into every stage
//   d_i    : input word, enters stage 0
//   q_o    : word from the last stage (d_i delayed by N clocks)
module vga_delay_line
    import vga_timing_gen_pkg::*;
#(
    parameter int             N       = 1,
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [N-1:0][W-1:0] stage_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= {N{RST_VAL}};
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < N; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[N-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA timing from a 25 MHz pixel clock.
// Presents the visible pixel address to the display stage, accepts its colour
// DATA_LAT (0..4) clocks later, and registers colour, syncs and blank so the
// pins all describe the same pixel.
//   clk         : pixel clock
//   clrn        : asynchronous active-low reset
//   en          : display enable; low forces black, timing keeps running
//   vga_data    : {R,G,B} for the address presented DATA_LAT clocks earlier
//   h_addr      : visible column, 0 outside the visible window
//   v_addr      : visible row, 0 outside the visible window
//   frame_done  : high during the last clock of each frame
//   vga_hs/vs   : registered syncs, active low
//   vga_blank_n : registered, high while the output pixel is visible
//   vga_r/g/b   : registered colour
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int DATA_LAT = 1
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        en,
    input  logic [23:0] vga_data,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    output logic        frame_done,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       h_wrap, v_wrap;
    tim_t       raw, dly;

    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_n_q, blank_n_d;
    logic [23:0] rgb_q, rgb_d;

    always_comb begin
        h_wrap  = (h_cnt_q == H_TOT - 10'd1);
        v_wrap  = (v_cnt_q == V_TOT - 10'd1);
        h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        raw.vis = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        raw.hs  = in_range(h_cnt_q, H_VIS + H_FP, H_SYNC) ? SYNC_ACT : ~SYNC_ACT;
        raw.vs  = in_range(v_cnt_q, V_VIS + V_FP, V_SYNC) ? SYNC_ACT : ~SYNC_ACT;
    end

    assign h_addr     = raw.vis ? h_cnt_q : 10'd0;
    assign v_addr     = raw.vis ? v_cnt_q : 10'd0;
    assign frame_done = h_wrap && v_wrap;

    // Hold the timing bundle back by the display stage's read latency so it
    // meets vga_data for the same pixel at the output register.
    generate
        if (DATA_LAT == 0) begin : g_no_dly
            assign dly = raw;
        end else begin : g_dly
            vga_delay_line #(
                .N       (DATA_LAT),
                .W       (3),
                .RST_VAL (TIM_RST)
            ) u_dly (
                .clk_i  (clk),
                .rst_ni (clrn),
                .d_i    (raw),
                .q_o    (dly)
            );
        end
    endgenerate

    always_comb begin
        hs_d      = dly.hs;
        vs_d      = dly.vs;
        blank_n_d = dly.vis;
        rgb_d     = (dly.vis && en) ? vga_data : 24'h0;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hs_q      <= ~SYNC_ACT;
            vs_q      <= ~SYNC_ACT;
            blank_n_q <= 1'b0;
            rgb_q     <= '0;
        end else begin
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            rgb_q     <= rgb_d;
        end
    end

    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int NPIX = 420000;

    int lat_tab [3] = '{0, 1, 3};

    logic        clk  = 1'b0;
    logic        clrn = 1'b0;
    logic        en   = 1'b1;
    logic [23:0] vdat   [3];
    logic [9:0]  h_addr [3];
    logic [9:0]  v_addr [3];
    logic        fd [3], hs [3], vs [3], bl [3];
    logic [7:0]  r [3], g [3], b [3];
    logic [47:0] act_v [3];

    always #20 clk = ~clk;

    vga_timing_gen #(.DATA_LAT(0)) u0 (
        .clk(clk), .clrn(clrn), .en(en), .vga_data(vdat[0]),
        .h_addr(h_addr[0]), .v_addr(v_addr[0]), .frame_done(fd[0]),
        .vga_hs(hs[0]), .vga_vs(vs[0]), .vga_blank_n(bl[0]),
        .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0]));

    vga_timing_gen #(.DATA_LAT(1)) u1 (
        .clk(clk), .clrn(clrn), .en(en), .vga_data(vdat[1]),
        .h_addr(h_addr[1]), .v_addr(v_addr[1]), .frame_done(fd[1]),
        .vga_hs(hs[1]), .vga_vs(vs[1]), .vga_blank_n(bl[1]),
        .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1]));

    vga_timing_gen #(.DATA_LAT(3)) u3 (
        .clk(clk), .clrn(clrn), .en(en), .vga_data(vdat[2]),
        .h_addr(h_addr[2]), .v_addr(v_addr[2]), .frame_done(fd[2]),
        .vga_hs(hs[2]), .vga_vs(vs[2]), .vga_blank_n(bl[2]),
        .vga_r(r[2]), .vga_g(g[2]), .vga_b(b[2]));

    for (genvar i = 0; i < 3; i++) begin : g_act
        assign act_v[i] = {h_addr[i], v_addr[i], fd[i], hs[i], vs[i], bl[i], r[i], g[i], b[i]};
    end

    // Display-stage stand-in: colour pattern of the address, returned after
    // each DUT's read latency.
    function automatic logic [23:0] pat(input logic [9:0] h, input logic [9:0] v);
        return {h[7:0], v[7:0], 8'hA5};
    endfunction

    logic [23:0]      d1;
    logic [2:0][23:0] d3;
    always @(posedge clk) begin
        d1 <= pat(h_addr[1], v_addr[1]);
        d3 <= {d3[1:0], pat(h_addr[2], v_addr[2])};
    end
    assign vdat[0] = pat(h_addr[0], v_addr[0]);
    assign vdat[1] = d1;
    assign vdat[2] = d3[2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int anchor_pos = 0;
    int anchor_cyc = 0;
    logic [9:0] jh, jv;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: the frame is a linear sequence of NPIX pixel slots;
    // the position is derived from clocks elapsed since the last known anchor.
    typedef struct {
        bit vld;
        int pos;
        bit en;
    } rec_t;
    rec_t hist [8];

    function automatic int cur_pos();
        return (anchor_pos + (cyc - anchor_cyc)) % NPIX;
    endfunction

    function automatic logic [47:0] model_out(input int d);
        int L, p, h, v, q, qh, qv;
        bit rst, vis, pv, phs, pvs;
        logic [9:0]  ea_h, ea_v;
        logic [23:0] prgb;
        L = lat_tab[d];
        p = hist[0].pos;
        h = p % 800;
        v = p / 800;
        vis = (h < 640) && (v < 480);
        ea_h = vis ? 10'(h) : 10'd0;
        ea_v = vis ? 10'(v) : 10'd0;
        rst = 1'b0;
        for (int i = 0; i <= L + 1; i++) if (!hist[i].vld) rst = 1'b1;
        if (rst) begin
            phs = 1'b1; pvs = 1'b1; pv = 1'b0; prgb = 24'h0;
        end else begin
            q  = hist[L+1].pos;
            qh = q % 800;
            qv = q / 800;
            pv   = (qh < 640) && (qv < 480);
            phs  = !((qh >= 656) && (qh < 752));
            pvs  = !((qv >= 490) && (qv < 492));
            prgb = (pv && hist[1].en) ? {8'(qh), 8'(qv), 8'hA5} : 24'h0;
        end
        return {ea_h, ea_v, (hist[0].vld && p == NPIX - 1), phs, pvs, pv, prgb};
    endfunction

    initial begin
        for (int i = 0; i < 8; i++) hist[i] = '{vld: 1'b0, pos: 0, en: 1'b0};
        forever begin
            @(negedge clk);
            for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
            hist[0].vld = clrn;
            hist[0].pos = clrn ? cur_pos() : 0;
            hist[0].en  = en;
            for (int d = 0; d < 3; d++)
                chk($sformatf("cyc%0d_lat%0d", cyc, lat_tab[d]), act_v[d], model_out(d));
        end
    end

    task automatic step();
        @(posedge clk);
        #5;
    endtask

    task automatic jump(input int h, input int v);
        jh = 10'(h);
        jv = 10'(v);
        force u0.h_cnt_q = jh; force u0.v_cnt_q = jv;
        force u1.h_cnt_q = jh; force u1.v_cnt_q = jv;
        force u3.h_cnt_q = jh; force u3.v_cnt_q = jv;
        #1;
        release u0.h_cnt_q; release u0.v_cnt_q;
        release u1.h_cnt_q; release u1.v_cnt_q;
        release u3.h_cnt_q; release u3.v_cnt_q;
        anchor_pos = v * 800 + h;
        anchor_cyc = cyc;
    endtask

    task automatic release_rst();
        clrn = 1'b1;
        anchor_pos = 0;
        anchor_cyc = cyc;
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        repeat (3) step();
        release_rst();
    endtask

    // Called right after reset release: hsync falls at 657+lat, lasts 96.
    task automatic measure_line(input string tag);
        int first [3];
        int low [3];
        int nz;
        nz = 0;
        for (int d = 0; d < 3; d++) begin first[d] = -1; low[d] = 0; end
        for (int k = 1; k <= 1000; k++) begin
            step();
            for (int d = 0; d < 3; d++) begin
                if (hs[d] == 1'b0) begin
                    low[d]++;
                    if (first[d] < 0) first[d] = k;
                end
            end
            if (k < 800 && h_addr[0] != 10'd0) nz++;
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_hs_fall_lat%0d", tag, lat_tab[d]), 48'(first[d]), 48'(657 + lat_tab[d]));
            chk($sformatf("%s_hs_width_lat%0d", tag, lat_tab[d]), 48'(low[d]), 48'd96);
        end
        chk({tag, "_haddr_nonzero"}, 48'(nz), 48'd639);
    endtask

    typedef struct {
        int         h;
        int         v;
        logic [9:0] eh;
        logic [9:0] ev;
        logic       efd;
    } vec_t;
    vec_t vecs [10];

    localparam logic [47:0] RST_VEC = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0};

    initial begin
        int first [3];
        int low [3];
        int cnt, at;

        vecs[0] = '{0,   0,   10'd0,   10'd0,   1'b0};
        vecs[1] = '{639, 0,   10'd639, 10'd0,   1'b0};
        vecs[2] = '{640, 0,   10'd0,   10'd0,   1'b0};
        vecs[3] = '{799, 0,   10'd0,   10'd0,   1'b0};
        vecs[4] = '{100, 479, 10'd100, 10'd479, 1'b0};
        vecs[5] = '{100, 480, 10'd0,   10'd0,   1'b0};
        vecs[6] = '{639, 479, 10'd639, 10'd479, 1'b0};
        vecs[7] = '{799, 524, 10'd0,   10'd0,   1'b1};
        vecs[8] = '{798, 524, 10'd0,   10'd0,   1'b0};
        vecs[9] = '{799, 523, 10'd0,   10'd0,   1'b0};

        clrn = 1'b0;
        en   = 1'b1;
        repeat (3) step();

        // Reset state and first clocks after release
        chk("reset_state", act_v[1], RST_VEC);
        release_rst();
        #1;
        chk("first_addr", {28'd0, h_addr[1], v_addr[1]}, 48'd0);
        step();
        chk("blank_clk1", 48'(bl[1]), 48'd0);
        chk("syncs_clk1", {46'd0, hs[1], vs[1]}, 48'd3);
        step();
        chk("blank_clk2", 48'(bl[1]), 48'd1);
        chk("rgb_clk2", {24'd0, r[1], g[1], b[1]}, {24'd0, 24'h0000A5});

        // One full line
        do_reset();
        measure_line("line");

        // Address / frame_done decode at chosen counter positions
        for (int i = 0; i < 10; i++) begin
            step();
            jump(vecs[i].h, vecs[i].v);
            #1;
            chk($sformatf("vec%0d", i), {27'd0, h_addr[1], v_addr[1], fd[1]},
                {27'd0, vecs[i].eh, vecs[i].ev, vecs[i].efd});
        end

        // Line wrap and frame wrap
        step();
        jump(799, 0);
        step();
        chk("line_wrap", {28'd0, h_addr[1], v_addr[1]}, {28'd0, 10'd0, 10'd1});
        step();
        jump(799, 524);
        #1;
        chk("frame_done_hi", 48'(fd[1]), 48'd1);
        step();
        chk("frame_wrap", {27'd0, h_addr[1], v_addr[1], fd[1]}, 48'd0);
        step();
        chk("frame_wrap_next", 48'(h_addr[1]), 48'd1);

        // Vertical sync window
        step();
        jump(799, 488);
        for (int d = 0; d < 3; d++) begin first[d] = -1; low[d] = 0; end
        for (int k = 1; k <= 2600; k++) begin
            step();
            for (int d = 0; d < 3; d++) begin
                if (vs[d] == 1'b0) begin
                    low[d]++;
                    if (first[d] < 0) first[d] = k;
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("vs_fall_lat%0d", lat_tab[d]), 48'(first[d]), 48'(802 + lat_tab[d]));
            chk($sformatf("vs_width_lat%0d", lat_tab[d]), 48'(low[d]), 48'd1600);
        end

        // frame_done pulses exactly once across the frame boundary
        step();
        jump(795, 524);
        cnt = 0;
        at  = -1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (fd[1]) begin cnt++; at = k; end
        end
        chk("fd_count", 48'(cnt), 48'd1);
        chk("fd_at", 48'(at), 48'd4);

        // Display enable low during the visible region
        do_reset();
        en = 1'b0;
        repeat (50) step();
        chk("en0_blank", 48'(bl[1]), 48'd1);
        chk("en0_rgb", {24'd0, r[1], g[1], b[1]}, 48'd0);
        chk("en0_hs", 48'(hs[1]), 48'd1);
        en = 1'b1;
        step();
        chk("en1_rgb", {24'd0, r[1], g[1], b[1]}, {24'd0, 8'd49, 8'd0, 8'hA5});

        // Random positions with random enable
        for (int it = 0; it < 12; it++) begin
            step();
            jump(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
            repeat (150) begin
                step();
                en = ($urandom_range(0, 3) != 0);
            end
        end
        en = 1'b1;

        // Asynchronous reset in the middle of a frame
        step();
        jump(299, 200);
        step();
        chk("pre_rst_blank", 48'(bl[1]), 48'd1);
        clrn = 1'b0;
        #1;
        for (int d = 0; d < 3; d++)
            chk($sformatf("async_rst_lat%0d", lat_tab[d]), act_v[d], RST_VEC);
        repeat (3) step();
        release_rst();
        measure_line("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
